// File: rtl/run_sequencer_if.sv
// Run-control bundle between the sequencer, control/alu and instr_ROM.
// The master drives instruction status; the slave returns pc, status and stats.
interface run_sequencer_if #(
    parameter int PC_WIDTH  = 11,
    parameter int CNT_WIDTH = 16
);
    logic                 start;
    logic                 branch_en;
    logic [PC_WIDTH-1:0]  target;
    logic                 mem_access;
    logic                 halt_inst;
    logic [PC_WIDTH-1:0]  pc;
    logic                 commit;
    logic                 busy;
    logic                 done;
    logic [CNT_WIDTH-1:0] cycle_count;
    logic [CNT_WIDTH-1:0] inst_count;

    modport master (
        output start, branch_en, target, mem_access, halt_inst,
        input  pc, commit, busy, done, cycle_count, inst_count
    );

    modport slave (
        input  start, branch_en, target, mem_access, halt_inst,
        output pc, commit, busy, done, cycle_count, inst_count
    );
endinterface

// File: rtl/run_sequencer.sv
// Program-run controller: owns pc, start/done handshake, memory stalls,
// halt detection and saturating run statistics.
module run_sequencer #(
    parameter int PC_WIDTH    = 11,
    parameter int HALT_PC     = 78,
    parameter int MEM_LATENCY = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic            clk,
    input  logic            reset,
    run_sequencer_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_STALL,
        S_DONE
    } state_t;

    localparam int WW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int WSTART_I = (MEM_LATENCY > 0) ? MEM_LATENCY - 1 : 0;
    localparam logic [WW-1:0] WSTART = WW'(WSTART_I);
    localparam logic [PC_WIDTH:0] HALT_V = (PC_WIDTH + 1)'(HALT_PC);
    localparam logic [CNT_WIDTH-1:0] CMAX = '1;
    localparam bit HAS_STALL = (MEM_LATENCY > 0);

    state_t               state_q, state_d;
    logic [PC_WIDTH-1:0]  pc_q, pc_d;
    logic [WW-1:0]        wcnt_q, wcnt_d;
    logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
    logic [CNT_WIDTH-1:0] inst_q, inst_d;
    logic                 armed_q, armed_d;
    logic                 done_q, done_d;

    logic [PC_WIDTH:0]    pc_inc;
    logic [PC_WIDTH-1:0]  nxt;
    logic                 fin;
    logic                 commit;

    // Next-state, commit gating, pc update and counter saturation
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        wcnt_d  = wcnt_q;
        cyc_d   = cyc_q;
        inst_d  = inst_q;
        armed_d = armed_q;
        commit  = 1'b0;
        pc_inc  = {1'b0, pc_q} + 1'b1;
        nxt     = bus.branch_en ? bus.target : pc_inc[PC_WIDTH-1:0];
        fin     = ({1'b0, nxt} >= HALT_V) || pc_inc[PC_WIDTH];

        unique case (state_q)
            S_IDLE: begin
                if (armed_q) begin
                    state_d = S_RUN;
                    armed_d = 1'b0;
                end
            end
            S_RUN: begin
                if (bus.mem_access && HAS_STALL) begin
                    state_d = S_STALL;
                    wcnt_d  = WSTART;
                end else begin
                    commit = 1'b1;
                end
            end
            S_STALL: begin
                if (wcnt_q != '0) begin
                    wcnt_d = wcnt_q - 1'b1;
                end else begin
                    commit = 1'b1;
                end
            end
            S_DONE: begin
            end
        endcase

        if ((state_q == S_RUN || state_q == S_STALL) && cyc_q != CMAX) begin
            cyc_d = cyc_q + 1'b1;
        end

        if (commit) begin
            if (inst_q != CMAX) begin
                inst_d = inst_q + 1'b1;
            end
            if (bus.halt_inst) begin
                state_d = S_DONE;
            end else begin
                pc_d    = nxt;
                state_d = fin ? S_DONE : S_RUN;
            end
        end

        if (bus.start) begin
            state_d = S_IDLE;
            pc_d    = '0;
            wcnt_d  = '0;
            cyc_d   = '0;
            inst_d  = '0;
            armed_d = 1'b1;
        end
    end

    assign done_d = (state_d == S_DONE);

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            wcnt_q  <= '0;
            cyc_q   <= '0;
            inst_q  <= '0;
            armed_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wcnt_q  <= wcnt_d;
            cyc_q   <= cyc_d;
            inst_q  <= inst_d;
            armed_q <= armed_d;
            done_q  <= done_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.commit      = commit;
    assign bus.busy        = (state_q == S_RUN) || (state_q == S_STALL);
    assign bus.done        = done_q;
    assign bus.cycle_count = cyc_q;
    assign bus.inst_count  = inst_q;
endmodule

// File: tb/tb_run_sequencer.sv
// Directed bench for run_sequencer: three parameter sets share one
// stimulus stream; each scenario checks the instance it targets.
module tb_run_sequencer;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        br;
    logic        mem;
    logic        halt;
    logic [10:0] tgt;

    int ncmp  = 0;
    int nfail = 0;

    run_sequencer_if #(.PC_WIDTH(11), .CNT_WIDTH(16)) ia ();
    run_sequencer_if #(.PC_WIDTH(11), .CNT_WIDTH(3))  ib ();
    run_sequencer_if #(.PC_WIDTH(4),  .CNT_WIDTH(16)) ic ();

    assign ia.start = start;
    assign ia.branch_en = br;
    assign ia.target = tgt;
    assign ia.mem_access = mem;
    assign ia.halt_inst = halt;
    assign ib.start = start;
    assign ib.branch_en = br;
    assign ib.target = tgt;
    assign ib.mem_access = mem;
    assign ib.halt_inst = halt;
    assign ic.start = start;
    assign ic.branch_en = br;
    assign ic.target = tgt[3:0];
    assign ic.mem_access = mem;
    assign ic.halt_inst = halt;

    run_sequencer #(.PC_WIDTH(11), .HALT_PC(8), .MEM_LATENCY(2), .CNT_WIDTH(16))
        ua (.clk(clk), .reset(reset), .bus(ia.slave));
    run_sequencer #(.PC_WIDTH(11), .HALT_PC(10), .MEM_LATENCY(2), .CNT_WIDTH(3))
        ub (.clk(clk), .reset(reset), .bus(ib.slave));
    run_sequencer #(.PC_WIDTH(4), .HALT_PC(15), .MEM_LATENCY(2), .CNT_WIDTH(16))
        uc (.clk(clk), .reset(reset), .bus(ic.slave));

    always #5 clk = ~clk;

    task automatic step;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        br    = 1'b0;
        mem   = 1'b0;
        halt  = 1'b0;
        tgt   = '0;
        step;
        step;
        chk("rst_pc", 32'(ia.pc), 0);
        chk("rst_done", 32'(ia.done), 0);
        chk("rst_busy", 32'(ia.busy), 0);
        chk("rst_commit", 32'(ia.commit), 0);
        chk("rst_cyc", 32'(ia.cycle_count), 0);
        chk("rst_inst", 32'(ia.inst_count), 0);

        // scenario 1: straight-line run to HALT_PC=8
        reset = 1'b0;
        start = 1'b1;
        step;
        start = 1'b0;
        step;
        for (int i = 0; i < 8; i++) begin
            chk("t1_pc", 32'(ia.pc), 32'(i));
            chk("t1_commit", 32'(ia.commit), 1);
            chk("t1_done", 32'(ia.done), 0);
            step;
        end
        chk("t1_done_end", 32'(ia.done), 1);
        chk("t1_pc_end", 32'(ia.pc), 8);
        chk("t1_inst", 32'(ia.inst_count), 8);
        chk("t1_cyc", 32'(ia.cycle_count), 8);
        chk("t1_busy", 32'(ia.busy), 0);
        chk("t1_commit_done", 32'(ia.commit), 0);

        // scenario 2: memory stall at pc=3
        start = 1'b1;
        step;
        start = 1'b0;
        step;
        for (int i = 0; i < 3; i++) begin
            chk("t2_pc", 32'(ia.pc), 32'(i));
            step;
        end
        mem = 1'b1;
        #1;
        chk("t2_s0_pc", 32'(ia.pc), 3);
        chk("t2_s0_commit", 32'(ia.commit), 0);
        chk("t2_s0_busy", 32'(ia.busy), 1);
        step;
        chk("t2_s1_pc", 32'(ia.pc), 3);
        chk("t2_s1_commit", 32'(ia.commit), 0);
        step;
        chk("t2_s2_pc", 32'(ia.pc), 3);
        chk("t2_s2_commit", 32'(ia.commit), 1);
        step;
        mem = 1'b0;
        for (int i = 4; i < 8; i++) begin
            chk("t2_pc", 32'(ia.pc), 32'(i));
            step;
        end
        chk("t2_done", 32'(ia.done), 1);
        chk("t2_inst", 32'(ia.inst_count), 8);
        chk("t2_cyc", 32'(ia.cycle_count), 10);

        // scenario 3: branch back, then halt beats branch
        start = 1'b1;
        step;
        start = 1'b0;
        step;
        for (int i = 0; i < 5; i++) begin
            chk("t3_pc", 32'(ia.pc), 32'(i));
            step;
        end
        chk("t3_pc5", 32'(ia.pc), 5);
        br  = 1'b1;
        tgt = 11'd2;
        step;
        br = 1'b0;
        chk("t3_br_pc", 32'(ia.pc), 2);
        step;
        chk("t3_pc3", 32'(ia.pc), 3);
        step;
        chk("t3_pc4", 32'(ia.pc), 4);
        halt = 1'b1;
        br   = 1'b1;
        #1;
        chk("t3_halt_commit", 32'(ia.commit), 1);
        chk("t3_halt_notdone", 32'(ia.done), 0);
        step;
        halt = 1'b0;
        br   = 1'b0;
        chk("t3_done", 32'(ia.done), 1);
        chk("t3_pc_hold", 32'(ia.pc), 4);
        chk("t3_inst", 32'(ia.inst_count), 9);
        chk("t3_cyc", 32'(ia.cycle_count), 9);
        chk("t3_busy", 32'(ia.busy), 0);
        step;
        chk("t3_pc_frozen", 32'(ia.pc), 4);
        chk("t3_done_hold", 32'(ia.done), 1);

        // scenario 4: abort mid-run with start
        start = 1'b1;
        step;
        start = 1'b0;
        step;
        for (int i = 0; i < 4; i++) step;
        chk("t4_pc4", 32'(ia.pc), 4);
        start = 1'b1;
        step;
        chk("t4_abort_pc", 32'(ia.pc), 0);
        chk("t4_abort_inst", 32'(ia.inst_count), 0);
        chk("t4_abort_cyc", 32'(ia.cycle_count), 0);
        chk("t4_abort_done", 32'(ia.done), 0);
        chk("t4_abort_busy", 32'(ia.busy), 0);
        start = 1'b0;
        step;
        chk("t4_rerun_busy", 32'(ia.busy), 1);
        chk("t4_rerun_pc", 32'(ia.pc), 0);
        chk("t4_rerun_cyc", 32'(ia.cycle_count), 0);
        step;
        chk("t4_pc1", 32'(ia.pc), 1);
        chk("t4_cyc1", 32'(ia.cycle_count), 1);
        chk("t4_inst1", 32'(ia.inst_count), 1);

        // scenario 5: reset during a stall, then require a start pulse
        mem = 1'b1;
        step;
        chk("t5_stall_busy", 32'(ia.busy), 1);
        chk("t5_stall_commit", 32'(ia.commit), 0);
        chk("t5_stall_pc", 32'(ia.pc), 1);
        reset = 1'b1;
        step;
        reset = 1'b0;
        mem   = 1'b0;
        chk("t5_rst_pc", 32'(ia.pc), 0);
        chk("t5_rst_busy", 32'(ia.busy), 0);
        chk("t5_rst_done", 32'(ia.done), 0);
        chk("t5_rst_commit", 32'(ia.commit), 0);
        chk("t5_rst_cyc", 32'(ia.cycle_count), 0);
        chk("t5_rst_inst", 32'(ia.inst_count), 0);
        step;
        step;
        chk("t5_idle_busy", 32'(ia.busy), 0);
        chk("t5_idle_pc", 32'(ia.pc), 0);
        start = 1'b1;
        step;
        start = 1'b0;
        step;
        chk("t5_run_busy", 32'(ia.busy), 1);
        step;
        chk("t5_run_pc1", 32'(ia.pc), 1);

        // scenario 6a: 3-bit counters saturate at 7
        start = 1'b1;
        step;
        start = 1'b0;
        step;
        for (int i = 0; i < 10; i++) begin
            chk("t6_pc", 32'(ib.pc), 32'(i));
            if (i == 7) begin
                chk("t6_inst7", 32'(ib.inst_count), 7);
                chk("t6_cyc7", 32'(ib.cycle_count), 7);
            end
            if (i == 9) begin
                chk("t6_inst_sat", 32'(ib.inst_count), 7);
                chk("t6_cyc_sat", 32'(ib.cycle_count), 7);
            end
            step;
        end
        chk("t6_done", 32'(ib.done), 1);
        chk("t6_pc_end", 32'(ib.pc), 10);
        chk("t6_inst_end", 32'(ib.inst_count), 7);
        chk("t6_cyc_end", 32'(ib.cycle_count), 7);

        // scenario 6b: 4-bit pc, HALT_PC=15
        start = 1'b1;
        step;
        start = 1'b0;
        br    = 1'b1;
        tgt   = 11'd14;
        step;
        chk("t6b_pc0", 32'(ic.pc), 0);
        chk("t6b_busy", 32'(ic.busy), 1);
        step;
        br = 1'b0;
        chk("t6b_pc14", 32'(ic.pc), 14);
        chk("t6b_run14", 32'(ic.busy), 1);
        step;
        chk("t6b_done15", 32'(ic.done), 1);
        chk("t6b_pc15", 32'(ic.pc), 15);
        start = 1'b1;
        step;
        start = 1'b0;
        br    = 1'b1;
        tgt   = 11'd15;
        step;
        chk("t6c_pc0", 32'(ic.pc), 0);
        step;
        br = 1'b0;
        chk("t6c_done", 32'(ic.done), 1);
        chk("t6c_pc15", 32'(ic.pc), 15);
        chk("t6c_inst", 32'(ic.inst_count), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
